// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice (two half adders + OR) reused over WIDTH cycles.
// Latency: operands accepted on edge N, result valid after edge N+WIDTH.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_sh_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             carry_nxt;
    logic             s0, c0, s1, c1;
    logic             last_bit;

    // Single full-adder slice working on the LSBs of the operand shifters
    half_adder u_ha0 (.a(sha[0]), .b(shb[0]), .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0),     .b(carry),  .s(s1), .c(c1));

    assign carry_nxt  = c0 | c1;
    assign sum_sh_nxt = WIDTH'({s1, sum_sh} >> 1);
    assign last_bit   = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sha    <= '0;
            shb    <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sha    <= a;
                        shb    <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                    end
                end
                RUN: begin
                    sha    <= sha >> 1;
                    shb    <= shb >> 1;
                    sum_sh <= sum_sh_nxt;
                    carry  <= carry_nxt;
                    cnt    <= cnt + 1'b1;
                    // Outputs only move on entry to DONE so they read as the last result elsewhere
                    if (last_bit) begin
                        sum  <= sum_sh_nxt;
                        cout <= carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): sums, latency, backpressure,
// mid-run reset and operand changes while busy.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Wait (bounded) for out_valid; returns the number of edges waited
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic [W-1:0] es, input logic ec, input int hold);
        int cyc;
        chk({tag, "_rdy_before"}, in_ready, 1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        wait_done(cyc);
        chk({tag, "_latency"}, cyc, W);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_rdy_done"}, in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_vld"}, out_valid, 1);
            chk({tag, "_hold_sum"}, {cout, sum}, {ec, es});
            chk({tag, "_hold_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle_vld"}, out_valid, 0);
        chk({tag, "_idle_rdy"}, in_ready, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_keep"}, {cout, sum}, {ec, es});
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #2;
        chk("rst_rdy",  in_ready, 1);
        chk("rst_vld",  out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res",  {cout, sum}, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("t1", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 0);
        run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run_op("t3", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
        run_op("t4", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 20);

        // Reset during the 4th RUN cycle
        a = 8'h77; b = 8'h66; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_vld",  out_valid, 0);
        chk("t5_rst_rdy",  in_ready, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_res",  {cout, sum}, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t5_no_vld", out_valid, 0);
            if (i == 1) rst_n = 1'b1;
        end
        run_op("t5_add", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0);

        // New operands presented while busy must not disturb the running add
        a = 8'h3C; b = 8'h5A; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'h11; b = 8'h22; cin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = ~in_valid;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        wait_done(cyc);
        chk("t6_sum",  sum, 8'h96);
        chk("t6_cout", cout, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t6_idle_rdy", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t6_accept2", busy, 1);
        wait_done(cyc);
        chk("t6_lat2",  cyc, W);
        chk("t6_sum2",  sum, 8'h34);
        chk("t6_cout2", cout, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t6_end_rdy", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
